// File: rtl/lbist_pkg.sv
// LBIST controller shared definitions: FSM state encoding and default widths.
// Consumers import with: import lbist_pkg::*;
package lbist_pkg;

    localparam int BITS_DEF     = 4;
    localparam int SIG_BITS_DEF = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

endpackage

// File: rtl/lbist_ctrl_comp.sv
// Equality comparator used for MISR signature vs golden check.
module comp #(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            eq
);

    assign eq = (a == b);

endmodule

// File: rtl/lbist_ctrl.sv
// LBIST session controller: sequences RPG/MISR, counts patterns, checks signature.
// Optional watchdog abort enabled by defining LBIST_TIMEOUT_EN.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int BITS     = BITS_DEF,
    parameter int SIG_BITS = SIG_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                rpg_end,
    input  logic [SIG_BITS-1:0] signature,
    input  logic [SIG_BITS-1:0] golden,
    output logic                rpg_rst,
    output logic                misr_clr,
    output logic                test_en,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [BITS-1:0]     pat_cnt,
    output logic                timeout
);

    logic [2:0]      state_q, state_d;
    logic [BITS-1:0] pat_cnt_q, pat_cnt_d;
    logic            pass_q, pass_d;
    logic            sig_eq;
    logic            first_run;
    logic            cnt_full;
`ifdef LBIST_TIMEOUT_EN
    logic            timeout_q, timeout_d;
`endif

    comp #(.BITS(SIG_BITS)) u_comp (
        .a  (signature),
        .b  (golden),
        .eq (sig_eq)
    );

    // pat_cnt is zero only in the first RUN cycle, where the LFSR still sits on the seed
    assign first_run = (pat_cnt_q == '0);
    assign cnt_full  = &pat_cnt_q;

    always_comb begin
        state_d   = state_q;
        pat_cnt_d = pat_cnt_q;
        pass_d    = pass_q;
`ifdef LBIST_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_INIT;
                    pat_cnt_d = '0;
                    pass_d    = 1'b0;
`ifdef LBIST_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            S_INIT: begin
                pat_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (!first_run && rpg_end) begin
                    state_d = S_SETTLE;
                end
`ifdef LBIST_TIMEOUT_EN
                else if (cnt_full) begin
                    state_d   = S_DONE;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end
`endif
                else if (!cnt_full) begin
                    pat_cnt_d = pat_cnt_q + BITS'(1);
                end
            end
            S_SETTLE: state_d = S_CHECK;
            S_CHECK: begin
                pass_d  = sig_eq;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pat_cnt_q <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_cnt_q <= pat_cnt_d;
            pass_q    <= pass_d;
        end
    end

`ifdef LBIST_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) timeout_q <= 1'b0;
        else     timeout_q <= timeout_d;
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign rpg_rst  = (state_q == S_INIT);
    assign misr_clr = (state_q == S_INIT);
    assign test_en  = (state_q == S_RUN);
    assign busy     = (state_q == S_INIT) || (state_q == S_RUN) ||
                      (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done     = (state_q == S_DONE);
    assign pass     = pass_q;
    assign pat_cnt  = pat_cnt_q;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Self-checking bench for lbist_ctrl with a period-based RPG environment model.
module tb_lbist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rpg_end;
    logic [3:0] signature;
    logic [3:0] golden;
    logic       rpg_rst, misr_clr, test_en, busy, done, pass, timeout;
    logic [3:0] pat_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // RPG environment: rpg_end is high whenever the pattern position wraps to the seed
    int per   = 15;
    int pos   = 0;
    bit hold0 = 1'b0;

    always #5 clk = ~clk;

    lbist_ctrl #(.BITS(4), .SIG_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rpg_end   (rpg_end),
        .signature (signature),
        .golden    (golden),
        .rpg_rst   (rpg_rst),
        .misr_clr  (misr_clr),
        .test_en   (test_en),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .pat_cnt   (pat_cnt),
        .timeout   (timeout)
    );

    always @(posedge clk) begin
        if (rpg_rst)      pos <= 0;
        else if (test_en) pos <= (pos + 1) % per;
    end

    assign rpg_end = hold0 ? 1'b0 : (pos == 0);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"},
              {25'd0, rpg_rst, misr_clr, test_en, busy, done, pass, timeout}, 0);
        check({tag, "_cnt"}, pat_cnt, 0);
    endtask

    // One session: start sampled at edge 0; L patterns until rpg_end returns
    task automatic run_session(input int L, input bit eq, input bit restart);
        logic [3:0] s;
        int n;
        per   = L;
        hold0 = 1'b0;
        s = 4'($urandom);
        signature = s;
        golden = eq ? s : (s ^ 4'($urandom_range(1, 15)));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("init_rpg_rst", rpg_rst, 1);
        check("init_misr_clr", misr_clr, 1);
        check("init_test_en", test_en, 0);
        check("init_busy", busy, 1);
        check("init_done", done, 0);
        check("init_pat_cnt", pat_cnt, 0);
        n = 0;
        while (n < 60 && !done) begin
            @(posedge clk);
            n++;
            #1;
            start = restart && (n >= 4) && (n <= 6);
            if (n == 1) check("run_test_en", test_en, 1);
        end
        start = 1'b0;
        check("latency", n, L + 4);
        check("final_cnt", pat_cnt, L);
        check("pass", pass, eq);
        check("timeout", timeout, 0);
        check("done_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        check("done_hold", done, 1);
        check("cnt_hold", pat_cnt, L);
        check("pass_hold", pass, eq);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        signature = '0;
        golden = '0;
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        run_session(15, 1'b1, 1'b0);
        run_session(15, 1'b0, 1'b0);
        run_session(15, 1'b1, 1'b1);

        // Asynchronous reset in the middle of RUN
        per = 15;
        hold0 = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_run_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle", busy, 0);
        run_session(15, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_session($urandom_range(1, 15), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
        end

        // RPG never returns to seed
        per = 15;
        hold0 = 1'b1;
        signature = 4'h3;
        golden = 4'h3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef LBIST_TIMEOUT_EN
        n = 0;
        while (n < 60 && !done) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("to_latency", n, 17);
        check("to_flag", timeout, 1);
        check("to_pass", pass, 0);
        check("to_cnt", pat_cnt, 15);
        check("to_busy", busy, 0);
`else
        n = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
        check("no_to_done", n, 0);
        check("no_to_busy", busy, 1);
        check("no_to_flag", timeout, 0);
        check("no_to_cnt", pat_cnt, 15);
`endif
        rst = 1'b1;
        #1;
        check_all_zero("final_rst");
        hold0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lbist_ctrl.md
LBIST_CTRL -- requirements
Module: lbist_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 4: RPG LFSR width and pat_cnt width.
REQ-002 SHALL have parameter SIG_BITS, default 4: MISR signature width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request a BIST session; level-sampled on posedge.
REQ-006 SHALL have port rpg_end  input  1  RPG END: LFSR register equals seed.
REQ-007 SHALL have port signature  input  SIG_BITS  current MISR signature.
REQ-008 SHALL have port golden  input  SIG_BITS  expected signature; stable while busy.
REQ-009 SHALL have port rpg_rst  output  1  RPG reset pulse: return LFSR to seed.
REQ-010 SHALL have port misr_clr  output  1  MISR clear pulse.
REQ-011 SHALL have port test_en  output  1  enable for RPG, MISR and CUT capture.
REQ-012 SHALL have port busy  output  1  session in progress.
REQ-013 SHALL have port done  output  1  result valid; held until next session starts.
REQ-014 SHALL have port pass  output  1  signature matched; valid only while done=1.
REQ-015 SHALL have port pat_cnt  output  BITS  patterns applied in current or last session.
REQ-016 SHALL have port timeout  output  1  session aborted by watchdog.

Function
REQ-017 SHALL implement FSM IDLE, INIT, RUN, SETTLE, CHECK, DONE.
REQ-018 SHALL decode every output from registered state or flops only; no combinational path from inputs.
REQ-019 IDLE or DONE with start=1 SHALL go to INIT and clear done, pass, timeout; start in any other state is ignored.
REQ-020 INIT SHALL last one cycle with rpg_rst=1, misr_clr=1, test_en=0, pat_cnt cleared to 0, then go to RUN.
REQ-021 RUN SHALL assert test_en=1 and busy=1.
REQ-022 rpg_end SHALL be ignored in the first RUN cycle, because the register equals the seed.
REQ-023 Each RUN edge without exit SHALL increment pat_cnt; pat_cnt saturates at all-ones.
REQ-024 rpg_end=1 in any later RUN cycle SHALL go to SETTLE with no pat_cnt increment.
REQ-025 SETTLE SHALL last one cycle with test_en=0 so the final MISR capture lands, then go to CHECK.
REQ-026 CHECK SHALL register pass = (signature == golden), then go to DONE.
REQ-027 DONE SHALL hold done=1 and busy=0; pat_cnt and pass are held.
REQ-028 busy SHALL be 1 in INIT, RUN, SETTLE and CHECK, else 0.
REQ-029 Latency, maximal LFSR, P = 2^BITS-1: state SHALL be DONE at edge P+4 after the edge that samples start, with final pat_cnt = P.

Reset
REQ-030 rst=1 SHALL force IDLE immediately, at any state including mid-RUN, and drive all outputs to 0.
REQ-031 After rst is deasserted, the block SHALL wait in IDLE for start.

Configuration
REQ-032 With LBIST_TIMEOUT_EN defined, a RUN cycle with pat_cnt all-ones and rpg_end=0 SHALL go directly to DONE with timeout=1, pass=0, skipping CHECK.
REQ-033 Without LBIST_TIMEOUT_EN, timeout SHALL be tied 0 and RUN waits for rpg_end indefinitely.

Structure
REQ-034 Shared package lbist_pkg SHALL hold the FSM state encoding constants and default BITS/SIG_BITS values.
REQ-035 Signature equality SHALL use existing sub-module comp, parameterised with BITS=SIG_BITS; no other sub-modules.

Verification
REQ-036 Setup: BITS=4, 4-bit maximal RPG, start pulse at edge 0, golden=signature -> done=1 at edge 19, pat_cnt=15, pass=1, timeout=0.
REQ-037 golden=4'hA, signature=4'h5 -> done=1 at edge 19, pass=0.
REQ-038 start re-asserted at edges 5..7 while busy -> ignored; done still at edge 19.
REQ-039 rst pulsed at edge 8 mid-RUN -> all outputs 0 at once; new start at edge 20 -> done at edge 39.
REQ-040 Forced rpg_end=1 in first RUN cycle only, then 0 until RUN cycle 16 -> not ended early; exit taken on cycle 16 as normal.
REQ-041 LBIST_TIMEOUT_EN defined, rpg_end held 0 -> done=1 at edge 17, timeout=1, pass=0; macro undefined -> done stays 0 for 100 cycles, busy=1.
